beat_sequencer: RTL and testbench

//  Consumes the slow clock level from the divider stage (e.g. clk4hz) and produces the

---
 rtl/model_clk_pkg.sv | 15 +
 rtl/step_debouncer.sv | 45 ++++
 rtl/beat_sequencer.sv | 105 ++++++++++
 tb/tb_beat_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/model_clk_pkg.sv
// Shared definitions for the model computer clock path: sequencer state encodings
// and default beat/debounce parameters.
package model_clk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_S  = 2'd1,
        STEP_S = 2'd2,
        HALT_S = 2'd3
    } state_t;

    localparam int unsigned NUM_BEATS_DEF = 4;
    localparam int unsigned DEBOUNCE_DEF  = 16;

endpackage

// File: rtl/step_debouncer.sv
// Debounces the raw STEP push-button and emits a 1-clk press pulse on each
// debounced 0->1 change of the button level.
module step_debouncer
    import model_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic CLEAR,
    input  logic raw,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // The button is asynchronous, so it passes a two-flop synchroniser first.
    always_ff @(posedge clk) begin
        if (CLEAR) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], raw};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_press <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/beat_sequencer.sv
// Turns rising edges of the divided slow clock into one-hot machine-cycle beats
// T1..TN, with continuous RUN, single-cycle STEP and end-of-cycle HALT.
module beat_sequencer
    import model_clk_pkg::*;
#(
    parameter int unsigned NUM_BEATS = NUM_BEATS_DEF,
    parameter int unsigned DEBOUNCE  = DEBOUNCE_DEF
) (
    input  logic                 clk,
    input  logic                 CLEAR,
    input  logic                 tick_in,
    input  logic                 RUN,
    input  logic                 STEP,
    input  logic                 HALT,
    output logic [NUM_BEATS-1:0] T,
    output logic                 beat_en,
    output logic                 cycle_done,
    output logic                 running,
    output logic                 halted
);

    localparam logic [NUM_BEATS-1:0] T1 = NUM_BEATS'(1);

    state_t               r_state;
    logic                 r_tick_d;
    logic [NUM_BEATS-1:0] r_t;
    logic                 r_beat_en;
    logic                 r_cycle_done;
    logic                 r_running;
    logic                 r_halted;
    logic                 w_rise;
    logic                 w_press;

    step_debouncer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_step_debouncer (
        .clk   (clk),
        .CLEAR (CLEAR),
        .raw   (STEP),
        .press (w_press)
    );

    assign w_rise = tick_in & ~r_tick_d;

    // Entry from IDLE ignores w_rise, so a rise on the entry edge is never used.
    always_ff @(posedge clk) begin
        if (CLEAR) begin
            r_state      <= IDLE;
            r_tick_d     <= 1'b0;
            r_t          <= '0;
            r_beat_en    <= 1'b0;
            r_cycle_done <= 1'b0;
            r_running    <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_tick_d     <= tick_in;
            r_beat_en    <= 1'b0;
            r_cycle_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (HALT) begin
                        r_state  <= HALT_S;
                        r_halted <= 1'b1;
                    end else if (RUN) begin
                        r_state   <= RUN_S;
                        r_running <= 1'b1;
                    end else if (w_press) begin
                        r_state   <= STEP_S;
                        r_running <= 1'b1;
                    end
                end
                RUN_S, STEP_S: begin
                    if (w_rise) begin
                        r_beat_en <= 1'b1;
                        if (r_t[NUM_BEATS-1]) begin
                            r_cycle_done <= 1'b1;
                            if ((r_state == RUN_S) && RUN && !HALT) begin
                                r_t <= T1;
                            end else begin
                                r_t       <= '0;
                                r_running <= 1'b0;
                                r_halted  <= HALT;
                                r_state   <= HALT ? HALT_S : IDLE;
                            end
                        end else if (r_t == '0) begin
                            r_t <= T1;
                        end else begin
                            r_t <= r_t << 1;
                        end
                    end
                end
                // HALT_S holds with T=0 until CLEAR.
                default: begin
                end
            endcase
        end
    end

    assign T          = r_t;
    assign beat_en    = r_beat_en;
    assign cycle_done = r_cycle_done;
    assign running    = r_running;
    assign halted     = r_halted;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer: a table of per-row input settings with the
// expected outputs after a given number of slow-clock rises, plus STEP/HALT sequences.
module tb_beat_sequencer;

    logic       clk = 1'b0;
    logic       CLEAR;
    logic       tick_in;
    logic       RUN;
    logic       STEP;
    logic       HALT;
    logic [3:0] T;
    logic       beat_en;
    logic       cycle_done;
    logic       running;
    logic       halted;

    int checks = 0;
    int errors = 0;

    beat_sequencer #(
        .NUM_BEATS (4),
        .DEBOUNCE  (4)
    ) dut (
        .clk        (clk),
        .CLEAR      (CLEAR),
        .tick_in    (tick_in),
        .RUN        (RUN),
        .STEP       (STEP),
        .HALT       (HALT),
        .T          (T),
        .beat_en    (beat_en),
        .cycle_done (cycle_done),
        .running    (running),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Slow clock: toggles every 5 clk, changed on the falling edge.
    initial begin
        tick_in = 1'b0;
        forever begin
            repeat (5) @(negedge clk);
            tick_in = ~tick_in;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       clear;
        logic       run;
        logic       step;
        logic       halt;
        int         rises;
        logic [3:0] t;
        logic       be;
        logic       cd;
        logic       rn;
        logic       hl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic c, logic r, logic s, logic h, int n,
                                logic [3:0] t, logic be, logic cd, logic rn, logic hl);
        vec_t v;
        v.clear = c; v.run = r; v.step = s; v.halt = h; v.rises = n;
        v.t = t; v.be = be; v.cd = cd; v.rn = rn; v.hl = hl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs, take one clk, then follow `rises` slow-clock rises; check after the last.
    task automatic apply_row(input int idx, input vec_t v);
        CLEAR = v.clear; RUN = v.run; STEP = v.step; HALT = v.halt;
        @(posedge clk);
        for (int k = 0; k < v.rises; k++) begin
            @(posedge tick_in);
            @(posedge clk);
        end
        #1;
        chk($sformatf("row%0d_T", idx), 32'(T), 32'(v.t));
        chk($sformatf("row%0d_beat_en", idx), 32'(beat_en), 32'(v.be));
        chk($sformatf("row%0d_cycle_done", idx), 32'(cycle_done), 32'(v.cd));
        chk($sformatf("row%0d_running", idx), 32'(running), 32'(v.rn));
        chk($sformatf("row%0d_halted", idx), 32'(halted), 32'(v.hl));
    endtask

    logic        saw;
    logic [19:0] seq;
    int          ncd;
    int          nbeat;

    initial begin
        CLEAR = 1'b1; RUN = 1'b0; STEP = 1'b0; HALT = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        //               clr run stp hlt n   T        be cd rn hl
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0001, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0010, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0100, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'b1000, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0001, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0010, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0100, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'b1000, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0001, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'b0010, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2, 4'b1000, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0001, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2, 4'b0100, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'b1000, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'b0000, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 2, 4'b0000, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2, 4'b0010, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0001, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b0000, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));

        foreach (vecs[i]) apply_row(i, vecs[i]);
        CLEAR = 1'b0; RUN = 1'b0; HALT = 1'b0; STEP = 1'b0;
        clk1();

        // STEP bounce shorter than the debounce window must not start a cycle.
        saw = 1'b0;
        STEP = 1'b1; repeat (2) begin clk1(); saw |= running; end
        STEP = 1'b0; repeat (2) begin clk1(); saw |= running; end
        STEP = 1'b1; repeat (3) begin clk1(); saw |= running; end
        STEP = 1'b0; repeat (10) begin clk1(); saw |= running; end
        chk("step_bounce_no_cycle", 32'(saw), 32'd0);

        // A held STEP gives exactly one full cycle.
        STEP = 1'b1;
        for (int k = 0; k < 40 && !running; k++) clk1();
        chk("step_start", 32'(running), 32'd1);
        seq = '0; ncd = 0; nbeat = 0;
        for (int k = 0; k < 100 && running; k++) begin
            clk1();
            if (beat_en) begin seq = {seq[15:0], T}; nbeat++; end
            if (cycle_done) ncd++;
        end
        chk("step_beats", 32'(seq), 32'h12480);
        chk("step_nbeats", 32'(nbeat), 32'd5);
        chk("step_cycle_done", 32'(ncd), 32'd1);
        saw = 1'b0;
        repeat (30) begin clk1(); saw |= running | beat_en; end
        STEP = 1'b0;
        repeat (30) begin clk1(); saw |= running | beat_en; end
        chk("step_hold_single", 32'(saw), 32'd0);

        // A STEP press during RUN_S is discarded, not queued.
        RUN = 1'b1;
        for (int k = 0; k < 20 && !running; k++) clk1();
        chk("runstep_start", 32'(running), 32'd1);
        STEP = 1'b1; repeat (10) clk1();
        STEP = 1'b0; repeat (10) clk1();
        RUN = 1'b0;
        ncd = 0;
        for (int k = 0; k < 100 && running; k++) begin
            clk1();
            if (cycle_done) ncd++;
        end
        chk("runstep_stopped", 32'(running), 32'd0);
        chk("runstep_one_cycle_done", 32'(ncd), 32'd1);
        saw = 1'b0;
        repeat (60) begin clk1(); saw |= running | beat_en | (T != 4'b0000); end
        chk("runstep_no_extra", 32'(saw), 32'd0);

        // HALT_S ignores RUN and STEP until CLEAR.
        RUN = 1'b1; HALT = 1'b1; clk1();
        RUN = 1'b0; HALT = 1'b0;
        chk("halt_entered", 32'(halted), 32'd1);
        saw = 1'b0;
        STEP = 1'b1; repeat (12) begin clk1(); saw |= running | (T != 4'b0000); end
        STEP = 1'b0; RUN = 1'b1;
        repeat (30) begin clk1(); saw |= running | (T != 4'b0000); end
        chk("halt_ignores_inputs", 32'(saw), 32'd0);
        chk("halt_held", 32'(halted), 32'd1);
        CLEAR = 1'b1; RUN = 1'b0; clk1();
        CLEAR = 1'b0;
        chk("halt_cleared", 32'(halted), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
